// File: rtl/lfsr_traffic_gen.sv
// Pseudo-random memory traffic generator: free-running random reads/writes (MODE 0)
// or a write pass followed by a self-checking read-back pass (MODE 1).
module lfsr_traffic_gen #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 6,
    parameter logic [DATA_W-1:0] DATA_SEED = DATA_W'(8'h80),
    parameter logic [ADDR_W-1:0] ADDR_SEED = ADDR_W'(6'h20),
    parameter logic [DATA_W-1:0] DATA_TAPS = DATA_W'(8'hC0),
    parameter logic [ADDR_W-1:0] ADDR_TAPS = ADDR_W'(6'h30),
    parameter int unsigned       RW_BIT    = 5,
    parameter int unsigned       MODE      = 0,
    parameter int unsigned       NUM_TXN   = 32,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic              clk,
    input  logic              start,
    input  logic              en,
    input  logic              mem_ready,
    output logic              valid,
    output logic              rwb,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    input  logic              rvalid,
    input  logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [CNT_W-1:0]  txn_count,
    output logic [7:0]        err_count
);

    localparam int unsigned PASS_W = $clog2(NUM_TXN + 2);
    localparam int unsigned OUT_W  = $clog2(NUM_TXN + 2);
    localparam logic [PASS_W-1:0] LAST_IDX = PASS_W'(NUM_TXN - 1);

    // A zero seed would lock the LFSR at zero forever.
    localparam logic [DATA_W-1:0] DATA_INIT = (DATA_SEED == '0) ? DATA_W'(1) : DATA_SEED;
    localparam logic [ADDR_W-1:0] ADDR_INIT = (ADDR_SEED == '0) ? ADDR_W'(1) : ADDR_SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WPASS,
        S_RPASS,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic [DATA_W-1:0] data_step(input logic [DATA_W-1:0] s);
        return {s[DATA_W-2:0], ^(s & DATA_TAPS)};
    endfunction

    function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] s);
        return {s[ADDR_W-2:0], ^(s & ADDR_TAPS)};
    endfunction

    state_e              state_q, state_d;
    logic                valid_q, valid_d;
    logic                rwb_q, rwb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    txn_q, txn_d;
    logic [7:0]          err_q, err_d;
    logic [OUT_W-1:0]    outst_q, outst_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [PASS_W-1:0]   pass_q, pass_d;

    logic accept;
    logic last_txn;
    logic issuing;
    logic active;
    logic rd_ret;
    logic spurious;
    logic mismatch;
    logic out_inc;
    logic out_dec;

    assign accept   = valid_q & mem_ready;
    assign last_txn = (pass_q == LAST_IDX);
    assign issuing  = (state_q == S_RUN) || (state_q == S_WPASS) || (state_q == S_RPASS);
    assign active   = issuing || (state_q == S_DRAIN);
    assign rd_ret   = rvalid & active;
    assign spurious = rd_ret & (outst_q == '0);
    assign mismatch = rd_ret & ~spurious & (MODE == 1) & (rdata != exp_q);
    assign out_inc  = accept & rwb_q;
    assign out_dec  = rd_ret & ~spurious;

    // Next-state, request issue and read-return bookkeeping.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        rwb_d   = rwb_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        txn_d   = txn_q;
        err_d   = err_q;
        outst_d = outst_q;
        exp_d   = exp_q;
        pass_d  = pass_q;

        if (accept) begin
            txn_d  = txn_q + CNT_W'(1);
            data_d = data_step(data_q);
            addr_d = addr_step(addr_q);
        end

        // A raised request is held until accepted; en only gates new ones.
        if (issuing) begin
            if (accept) begin
                valid_d = en & ~last_txn;
                pass_d  = last_txn ? '0 : pass_q + PASS_W'(1);
            end else if (!valid_q) begin
                valid_d = en;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    valid_d = 1'b1;
                    pass_d  = '0;
                    if (MODE == 1) begin
                        state_d = S_WPASS;
                        rwb_d   = 1'b0;
                    end else begin
                        state_d = S_RUN;
                        rwb_d   = data_q[RW_BIT];
                    end
                end
            end
            S_RUN: begin
                rwb_d = data_d[RW_BIT];
                if (accept && last_txn) begin
                    state_d = S_DRAIN;
                end
            end
            S_WPASS: begin
                rwb_d = 1'b0;
                // Reload seeds so the read pass replays the write addresses.
                if (accept && last_txn) begin
                    state_d = S_RPASS;
                    data_d  = DATA_INIT;
                    addr_d  = ADDR_INIT;
                    rwb_d   = 1'b1;
                end
            end
            S_RPASS: begin
                rwb_d = 1'b1;
                if (accept && last_txn) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                valid_d = 1'b0;
                if (outst_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        case ({out_inc, out_dec})
            2'b10:   outst_d = outst_q + OUT_W'(1);
            2'b01:   outst_d = outst_q - OUT_W'(1);
            default: outst_d = outst_q;
        endcase

        if ((MODE == 1) && out_dec) begin
            exp_d = data_step(exp_q);
        end

        if ((spurious || mismatch) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // start acts as a synchronous reset and overrides everything else.
    always_ff @(posedge clk) begin
        if (start) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            rwb_q   <= 1'b1;
            addr_q  <= ADDR_INIT;
            data_q  <= DATA_INIT;
            done_q  <= 1'b0;
            txn_q   <= '0;
            err_q   <= '0;
            outst_q <= '0;
            exp_q   <= DATA_INIT;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rwb_q   <= rwb_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            txn_q   <= txn_d;
            err_q   <= err_d;
            outst_q <= outst_d;
            exp_q   <= exp_d;
            pass_q  <= pass_d;
        end
    end

    assign valid     = valid_q;
    assign rwb       = rwb_q;
    assign address   = addr_q;
    assign data      = data_q;
    assign done      = done_q;
    assign txn_count = txn_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_lfsr_traffic_gen.sv
// Directed bench for lfsr_traffic_gen: a MODE 0 instance with defaults and a
// MODE 1 instance (NUM_TXN=8) driven by an in-order 1-cycle-latency memory model.
module tb_lfsr_traffic_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        start0, en0, rdy0, valid0, rwb0, rvalid0, done0;
    logic [5:0]  addr0;
    logic [7:0]  data0, rdata0, err0;
    logic [15:0] txn0;

    logic        start1, en1, rdy1, valid1, rwb1, rvalid1, done1;
    logic [5:0]  addr1;
    logic [7:0]  data1, rdata1, err1;
    logic [15:0] txn1;

    int checks   = 0;
    int failures = 0;

    lfsr_traffic_gen u_dut0 (
        .clk       (clk),
        .start     (start0),
        .en        (en0),
        .mem_ready (rdy0),
        .valid     (valid0),
        .rwb       (rwb0),
        .address   (addr0),
        .data      (data0),
        .rvalid    (rvalid0),
        .rdata     (rdata0),
        .done      (done0),
        .txn_count (txn0),
        .err_count (err0)
    );

    lfsr_traffic_gen #(
        .MODE    (1),
        .NUM_TXN (8)
    ) u_dut1 (
        .clk       (clk),
        .start     (start1),
        .en        (en1),
        .mem_ready (rdy1),
        .valid     (valid1),
        .rwb       (rwb1),
        .address   (addr1),
        .data      (data1),
        .rvalid    (rvalid1),
        .rdata     (rdata1),
        .done      (done1),
        .txn_count (txn1),
        .err_count (err1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model for u_dut1: writes land in mem, reads return in order one cycle later.
    logic [7:0] mem [64];
    logic [5:0] rd_q [$];
    bit         hold_ret    = 1'b0;
    int         rd_num      = 0;
    int         corrupt_idx = -1;

    initial begin
        logic [5:0] a;
        rvalid1 = 1'b0;
        rdata1  = 8'h00;
        forever begin
            @(negedge clk);
            rvalid1 = 1'b0;
            if (!hold_ret && rd_q.size() > 0) begin
                a      = rd_q.pop_front();
                rdata1 = mem[a];
                if (rd_num == corrupt_idx) rdata1 = rdata1 ^ 8'h01;
                rvalid1 = 1'b1;
                rd_num++;
            end
            if (valid1 && rdy1 && !start1) begin
                if (rwb1) rd_q.push_back(addr1);
                else      mem[addr1] = data1;
            end
        end
    end

    task automatic restart1(input int corrupt);
        start1 = 1'b1;
        en1    = 1'b0;
        rdy1   = 1'b1;
        step();
        rd_q.delete();
        rd_num      = 0;
        corrupt_idx = corrupt;
        hold_ret    = 1'b0;
        start1      = 1'b0;
        en1         = 1'b1;
    endtask

    task automatic wait_done1(input string tag);
        for (int k = 0; k < 200; k++) begin
            if (done1) break;
            step();
        end
        check_eq({tag, "_done"}, 32'(done1), 32'd1);
    endtask

    logic [7:0] exp_data [9] = '{8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h81};
    logic [5:0] exp_addr [7] = '{6'h20, 6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21};

    initial begin
        start0  = 1'b1; en0 = 1'b0; rdy0 = 1'b0; rvalid0 = 1'b0; rdata0 = 8'h00;
        start1  = 1'b1; en1 = 1'b0; rdy1 = 1'b0;
        step();
        step();

        check_eq("rst_valid", 32'(valid0), 32'd0);
        check_eq("rst_rwb",   32'(rwb0),   32'd1);
        check_eq("rst_addr",  32'(addr0),  32'h20);
        check_eq("rst_data",  32'(data0),  32'h80);
        check_eq("rst_done",  32'(done0),  32'd0);
        check_eq("rst_txn",   32'(txn0),   32'd0);
        check_eq("rst_err",   32'(err0),   32'd0);

        // Mode 0 sequence, one accept per cycle
        start0 = 1'b0; en0 = 1'b1; rdy0 = 1'b1;
        step();
        check_eq("t1_valid0", 32'(valid0), 32'd1);
        check_eq("t1_addr0",  32'(addr0),  32'h20);
        check_eq("t1_data0",  32'(data0),  32'h80);
        check_eq("t1_rwb0",   32'(rwb0),   32'd0);
        check_eq("t1_txn0",   32'(txn0),   32'd0);
        for (int i = 1; i < 9; i++) begin
            step();
            check_eq($sformatf("t1_data%0d", i), 32'(data0), 32'(exp_data[i]));
            check_eq($sformatf("t1_txn%0d", i),  32'(txn0),  32'(i));
            check_eq($sformatf("t1_rwb%0d", i),  32'(rwb0),  32'(exp_data[i][5]));
            if (i < 7) check_eq($sformatf("t1_addr%0d", i), 32'(addr0), 32'(exp_addr[i]));
        end

        // Stall: everything holds while mem_ready is low
        rdy0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("t2_valid%0d", i), 32'(valid0), 32'd1);
            check_eq($sformatf("t2_addr%0d", i),  32'(addr0),  32'h06);
            check_eq($sformatf("t2_data%0d", i),  32'(data0),  32'h81);
            check_eq($sformatf("t2_rwb%0d", i),   32'(rwb0),   32'd0);
            check_eq($sformatf("t2_txn%0d", i),   32'(txn0),   32'd8);
        end
        rdy0 = 1'b1;
        step();
        check_eq("t2_resume_data", 32'(data0), 32'h03);
        check_eq("t2_resume_addr", 32'(addr0), 32'h0C);
        check_eq("t2_resume_txn",  32'(txn0),  32'd9);
        en0 = 1'b0; rdy0 = 1'b0;

        // Mode 1 clean write/read-back run
        restart1(-1);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 1) begin
                check_eq("t3_wvalid", 32'(valid1), 32'd1);
                check_eq("t3_wrwb",   32'(rwb1),   32'd0);
                check_eq("t3_waddr",  32'(addr1),  32'h20);
                check_eq("t3_wdata",  32'(data1),  32'h80);
            end
        end
        check_eq("t3_gap_valid", 32'(valid1), 32'd0);
        check_eq("t3_gap_rwb",   32'(rwb1),   32'd1);
        check_eq("t3_gap_addr",  32'(addr1),  32'h20);
        check_eq("t3_gap_txn",   32'(txn1),   32'd8);
        wait_done1("t3");
        check_eq("t3_txn",   32'(txn1),   32'd16);
        check_eq("t3_err",   32'(err1),   32'd0);
        check_eq("t3_valid", 32'(valid1), 32'd0);

        // Third read corrupted
        restart1(2);
        wait_done1("t4");
        check_eq("t4_err", 32'(err1), 32'd1);
        check_eq("t4_txn", 32'(txn1), 32'd16);

        // en dropped while a write is stalled
        restart1(-1);
        rdy1 = 1'b0;
        step();
        step();
        en1 = 1'b0;
        step();
        check_eq("t5_pend_valid", 32'(valid1), 32'd1);
        check_eq("t5_pend_addr",  32'(addr1),  32'h20);
        rdy1 = 1'b1;
        step();
        check_eq("t5_acc_valid", 32'(valid1), 32'd0);
        check_eq("t5_acc_txn",   32'(txn1),   32'd1);
        check_eq("t5_acc_addr",  32'(addr1),  32'h01);
        step();
        step();
        check_eq("t5_idle_valid", 32'(valid1), 32'd0);
        check_eq("t5_idle_txn",   32'(txn1),   32'd1);
        en1 = 1'b1;
        step();
        check_eq("t5_res_valid", 32'(valid1), 32'd1);
        check_eq("t5_res_addr",  32'(addr1),  32'h01);
        check_eq("t5_res_data",  32'(data1),  32'h01);
        wait_done1("t5");
        check_eq("t5_txn", 32'(txn1), 32'd16);
        check_eq("t5_err", 32'(err1), 32'd0);

        // start during RPASS with two reads outstanding
        restart1(-1);
        hold_ret = 1'b1;
        for (int k = 1; k <= 12; k++) step();
        check_eq("t6_pre_valid", 32'(valid1), 32'd1);
        check_eq("t6_pre_rwb",   32'(rwb1),   32'd1);
        check_eq("t6_pre_txn",   32'(txn1),   32'd10);
        check_eq("t6_pre_held",  32'(rd_q.size()), 32'd2);
        start1 = 1'b1; en1 = 1'b0; rdy1 = 1'b0;
        step();
        start1 = 1'b0;
        check_eq("t6_rst_valid", 32'(valid1), 32'd0);
        check_eq("t6_rst_rwb",   32'(rwb1),   32'd1);
        check_eq("t6_rst_addr",  32'(addr1),  32'h20);
        check_eq("t6_rst_data",  32'(data1),  32'h80);
        check_eq("t6_rst_done",  32'(done1),  32'd0);
        check_eq("t6_rst_txn",   32'(txn1),   32'd0);
        check_eq("t6_rst_err",   32'(err1),   32'd0);
        hold_ret = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check_eq("t6_late_rets", 32'(rd_num),  32'd2);
        check_eq("t6_late_err",  32'(err1),    32'd0);
        check_eq("t6_late_valid", 32'(valid1), 32'd0);
        check_eq("t6_late_done", 32'(done1),   32'd0);
        check_eq("t6_late_txn",  32'(txn1),    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
